booth_multiplier_seq: RTL and testbench

//  Sequential radix-2 Booth multiplier: the inverse arithmetic partner of the non-restoring divider.

---
 rtl/mult_pkg.sv | 12 +
 rtl/booth_mult_ctrl.sv | 62 ++++++
 rtl/booth_multiplier_seq.sv | 108 ++++++++++
 tb/tb_booth_multiplier_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared arithmetic-unit definitions: multiplier FSM state
// encoding and the default operand width.
package mult_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EVAL  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int MULT_N = 4;

endpackage

// File: rtl/booth_mult_ctrl.sv
// Booth multiplier controller: IDLE/EVAL/SHIFT/DONE sequencing.
// BOOTH_SIGNED_EN selects Booth recoding, else plain add-shift.
module booth_mult_ctrl
    import mult_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] q0q1,
    input  logic       last,
    output logic       ld,
    output logic       add,
    output logic       sub,
    output logic       sft,
    output logic       decr,
    output logic       busy,
    output logic       done
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       in_eval;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state selection
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_EVAL;
            ST_EVAL:  state_nxt = ST_SHIFT;
            ST_SHIFT: state_nxt = last ? ST_DONE : ST_EVAL;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign in_eval = (state == ST_EVAL);
    assign ld      = (state == ST_IDLE) && start;
    assign sft     = (state == ST_SHIFT);
    assign decr    = (state == ST_SHIFT);
    assign busy    = in_eval || sft;
    assign done    = (state == ST_DONE);

`ifdef BOOTH_SIGNED_EN
    // Booth recoding: 01 adds M, 10 subtracts M
    assign add = in_eval && (q0q1 == 2'b01);
    assign sub = in_eval && (q0q1 == 2'b10);
`else
    // q_1 is held clear, so 10 means "multiplier bit set": add M
    assign add = in_eval && (q0q1 == 2'b10);
    assign sub = 1'b0;
`endif

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier datapath (A, Q, M, q_1, count).
// Define BOOTH_SIGNED_EN for two's complement operands.
module booth_multiplier_seq
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    // acc carries one guard bit so the most-negative case stays exact
    logic [N:0]    acc;
    logic [N-1:0]  m;
    logic [N-1:0]  q;
    logic          q_1;
    logic [CW-1:0] count;

    logic [N:0] mx;
    logic       fill;
    logic       q1_nxt;
    logic       last;

    logic ld;
    logic add;
    logic sub;
    logic sft;
    logic decr;

`ifdef BOOTH_SIGNED_EN
    assign mx     = {m[N-1], m};
    assign fill   = acc[N];
    assign q1_nxt = q[0];
`else
    assign mx     = {1'b0, m};
    assign fill   = 1'b0;
    assign q1_nxt = 1'b0;
`endif

    assign last = (count == CW'(1));

    booth_mult_ctrl u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .q0q1  ({q[0], q_1}),
        .last  (last),
        .ld    (ld),
        .add   (add),
        .sub   (sub),
        .sft   (sft),
        .decr  (decr),
        .busy  (busy),
        .done  (done)
    );

    // operand load, add/sub of M, and right shift of {A,Q,q_1}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            m   <= '0;
            q   <= '0;
            q_1 <= 1'b0;
        end else if (ld) begin
            acc <= '0;
            m   <= multiplicand;
            q   <= multiplier;
            q_1 <= 1'b0;
        end else if (add) begin
            acc <= acc + mx;
        end else if (sub) begin
            acc <= acc - mx;
        end else if (sft) begin
            acc <= {fill, acc[N:1]};
            q   <= {acc[0], q[N-1:1]};
            q_1 <= q1_nxt;
        end
    end

    // step counter, reloaded on every accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (ld) begin
            count <= CW'(N);
        end else if (decr) begin
            count <= count - CW'(1);
        end
    end

    // result captured from the final shift so it is valid with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (sft && last) begin
            product <= {acc, q[N-1:1]};
        end
    end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq (N=4):
// cycle-level reference model plus directed and random operations.
module tb_booth_multiplier_seq;

    localparam int N   = 4;
    localparam int LAT = 2 * N + 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] mc    = '0;
    logic [N-1:0] mr    = '0;
    logic [2*N-1:0] product;
    logic         busy;
    logic         done;

    int   errors = 0;
    int   checks = 0;
    logic chk_en = 1'b0;

    booth_multiplier_seq #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (mc),
        .multiplier   (mr),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_prod(
        input logic [3:0] a,
        input logic [3:0] b
    );
        int x;
        int y;
`ifdef BOOTH_SIGNED_EN
        x = int'($signed(a));
        y = int'($signed(b));
`else
        x = int'(a);
        y = int'(b);
`endif
        return 8'(x * y);
    endfunction

    task automatic chk(
        input string      name,
        input logic [7:0] act,
        input logic [7:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // reference: ph counts cycles since the accepted start
    int         ph;
    logic [7:0] pend;
    logic [7:0] mprod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph    <= 0;
            pend  <= '0;
            mprod <= '0;
        end else if (ph == 0) begin
            if (start) begin
                ph   <= 1;
                pend <= model_prod(mc, mr);
            end
        end else if (ph == LAT) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
            if (ph == LAT - 1) mprod <= pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 8'(busy), 8'(ph >= 1 && ph < LAT));
            chk("done", 8'(done), 8'(ph == LAT));
            chk("product", product, mprod);
        end
    end

    task automatic run_op(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [7:0] lit,
        input bit         pulse_mid
    );
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        mc    = a;
        mr    = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (pulse_mid && k == 4) begin
                start = 1'b1;
                mc    = ~a;
                mr    = 4'h5;
            end
            if (pulse_mid && k == 5) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                chk("latency", 8'(k), 8'(LAT));
                chk("lit_product", product, lit);
            end
        end
        if (!seen) chk("done_timeout", 8'd0, 8'd1);
    endtask

    initial begin
        int ndone;
        int first_k;
        int second_k;
        bit seen;

        repeat (2) @(negedge clk);
        chk("rst_product", product, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_done", 8'(done), 8'h00);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_op(4'd3, 4'd5, 8'h0F, 1'b0);
`ifdef BOOTH_SIGNED_EN
        run_op(4'hD, 4'd5, 8'hF1, 1'b0);
        run_op(4'h8, 4'h8, 8'h40, 1'b0);
        run_op(4'h7, 4'h8, 8'hC8, 1'b0);
`else
        run_op(4'hF, 4'hF, 8'hE1, 1'b0);
        run_op(4'hF, 4'h1, 8'h0F, 1'b0);
`endif
        run_op(4'd7, 4'd0, 8'h00, 1'b1);

        // reset in the middle of a 6 x 6 operation
        @(negedge clk);
        mc    = 4'd6;
        mr    = 4'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_product", product, 8'h00);
        chk("mid_rst_busy", 8'(busy), 8'h00);
        chk("mid_rst_done", 8'(done), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd2, 4'd2, 8'h04, 1'b0);

        // start held high: back-to-back ops, one idle cycle between
        @(negedge clk);
        mc    = 4'd3;
        mr    = 4'd3;
        start = 1'b1;
        @(posedge clk);
        ndone    = 0;
        first_k  = 0;
        second_k = 0;
        for (int k = 1; k <= 40 && ndone < 2; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) first_k = k;
                else second_k = k;
            end
        end
        start = 1'b0;
        chk("held_first", 8'(first_k), 8'(LAT));
        chk("held_second", 8'(second_k), 8'(2 * LAT + 1));
        chk("held_product", product, model_prod(4'd3, 4'd3));

        // randomized operations with stray starts and resets
        repeat (60) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            mc    = 4'($urandom);
            mr    = 4'($urandom);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            if ($urandom_range(0, 14) == 0) begin
                repeat ($urandom_range(1, 8)) @(negedge clk);
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end else begin
                seen = 1'b0;
                for (int k = 1; k <= 30 && !seen; k++) begin
                    @(negedge clk);
                    if (k == 3 && $urandom_range(0, 1) == 1) begin
                        start = 1'b1;
                        mc    = 4'($urandom);
                        mr    = 4'($urandom);
                    end
                    if (k == 4) start = 1'b0;
                    if (done) seen = 1'b1;
                end
                if (!seen) chk("rand_timeout", 8'd0, 8'd1);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
